pe_grid_12x14: RTL and testbench
================================

Name: pe_grid_12x14

Overview:
- Eyeriss-style 12-row × 14-column array of Q7.8 multiply-accumulate processing elements (PEs).
- Weights are loaded one grid row per transfer. Image values are broadcast down each column.
- Partial sums enter at the bottom row (row 11) and ripple upward to row 0, which drives psum_outs.
- Sits between the top-level sequencing FSM and the 14-input adder tree (adder_tree_14) that reduces psum_outs.

Parameters:
- ROWS, 12, number of PE rows.
- COLS, 14, number of PE columns; equals the vector lengths on the ports.
- DATA_W, 16, data width of weights, activations and partial sums (signed Q7.8).
- FRAC_BITS, 8, fractional bits of the Q format.
- TAG_W, 4, width of tag_row.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- image_val_vec  in  DATA_W×COLS  per-column activation value, unpacked [0:COLS-1].
- valid_x_vec  in  1×COLS  per-column activation-valid strobe.
- row_weight_vals  in  DATA_W×COLS  weights for one grid row, entry c goes to column c.
- tag_row  in  TAG_W  destination row index for row_weight_vals.
- valid_y  in  1  weight-load strobe.
- psum_ins  in  DATA_W×COLS  partial sums entering row ROWS-1.
- psum_outs  out  DATA_W×COLS  partial sums leaving row 0.

Behaviour:
- State per PE(r,c): w_reg (DATA_W), a_reg (DATA_W), a_vld (1 bit).
- Reset, rst=1 at a rising edge: all w_reg, a_reg and a_vld are cleared to 0.
  - Consequence: psum_outs[c] == psum_ins[c] from the cycle after reset.
  - Reset mid-operation discards all loaded weights and activations.
- Weight load, valid_y=1 at an edge with tag_row < ROWS:
  - Every PE(tag_row,c) loads w_reg <= row_weight_vals[c].
  - Other rows hold their weights.
  - tag_row >= ROWS (12..15) is ignored and no weights change.
  - valid_y=0 holds all weights.
- Activation load, every edge, each column c independently:
  - a_vld[r][c] <= valid_x_vec[c] for all r.
  - If valid_x_vec[c]=1, a_reg[r][c] <= image_val_vec[c] for all r. Otherwise a_reg holds.
- PE compute is combinational from the registers.
  - prod = signed(w_reg) × signed(a_reg) → 2·DATA_W bits, arithmetic shift right by FRAC_BITS (truncate toward −inf), keep low DATA_W bits.
  - contribution = a_vld ? prod : 0.
  - psum_out(r,c) = psum_in(r,c) + contribution, DATA_W-bit two's-complement wrap.
- Chain:
  - psum_in(ROWS-1,c) = psum_ins[c].
  - psum_in(r,c) = psum_out(r+1,c).
  - psum_outs[c] = psum_out(0,c).
- Latency:
  - Data/strobes presented before edge N are reflected on psum_outs after edge N (1 cycle).
  - psum_ins → psum_outs is combinational (0 cycles).
- Simultaneous valid_y and valid_x at the same edge: both take effect, and the next-cycle output uses the new weight and new activation.
- No handshake or backpressure. Strobes are single-cycle-sampled levels.

Optional Feature:
- Macro PE_GRID_SATURATE_EN.
- Defined:
  - Each shifted product saturates to [0x8000, 0x7FFF] instead of wrapping.
  - Each per-PE accumulate saturates to the same range.
- Undefined: wrap-around arithmetic as in Behaviour.
- Latency is identical in both builds.

Decomposition:
- Package eyeriss_pkg holds:
  - Constants GRID_ROWS=12, GRID_COLS=14, DATA_W=16, FRAC_BITS=8, TAG_W=4.
  - Typedef data_t (logic signed [15:0]).
  - Functions q_mul and q_add (with optional saturation).
- One sub-module pe_cell holds w_reg, a_reg, a_vld and the MAC. It is instantiated ROWS×COLS times via generate.
- adder_tree_14 and blk_mem_img remain separate blocks outside this module.

Test Plan:
- Identity MAC:
  - Stimulus: load rows 0-5 with weight 0x0100 in cols 0-5 (0 elsewhere); valid_x on cols 0-5 with image 0x0100; psum_ins=0.
  - Required: psum_outs[0..5]=0x0600 and psum_outs[6..13]=0 one cycle later; adder-tree sum 0x2400.
- Sign:
  - Stimulus: row 0 weight 0xFF00 (−1.0), col 0 image 0x0180 (1.5), psum_ins[0]=0x0040.
  - Required: psum_outs[0]=0xFEC0.
- Overflow:
  - Stimulus: row 0 weight 0x7F00, col 0 image 0x0200.
  - Required: psum_outs[0]=0xFE00 without PE_GRID_SATURATE_EN, 0x7FFF with it.
- Bad tag:
  - Stimulus: after the identity load, valid_y with tag_row=13 and weights 0x0500.
  - Required: outputs remain 0x0600.
- Valid gating:
  - Stimulus: drop valid_x_vec[2] for one cycle.
  - Required: psum_outs[2]=psum_ins[2] for exactly that following cycle, then 0x0600 when valid returns with the same image.
- Reset mid-run:
  - Stimulus: assert rst for 1 cycle after loads, psum_ins[c]=c.
  - Required: psum_outs[c]=c thereafter until new loads.

Source files
------------

// File: rtl/eyeriss_pkg.sv
// Shared definitions for the Eyeriss-style PE grid.
//
// Contents:
//   GRID_ROWS, GRID_COLS  default grid geometry (12 x 14)
//   DATA_W, FRAC_BITS     signed Q7.8 data format
//   TAG_W                 width of the weight-row destination tag
//   data_t                signed DATA_W-bit datum
//   q_mul                 Q-format multiply, arithmetic shift (floor)
//   q_add                 Q-format add
//
// Build option:
//   PE_GRID_SATURATE_EN   when defined, q_mul and q_add clamp to
//                         [0x8000, 0x7FFF]; otherwise they wrap.

package eyeriss_pkg;

  localparam int GRID_ROWS = 12;
  localparam int GRID_COLS = 14;
  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int TAG_W     = 4;

  typedef logic signed [DATA_W-1:0] data_t;

  localparam data_t DATA_MAX = 16'sh7FFF;
  localparam data_t DATA_MIN = 16'sh8000;

  // Full-precision signed product, then an arithmetic right shift so the
  // result is rounded toward minus infinity before narrowing.
  function automatic data_t q_mul(input data_t a, input data_t b, input int fracBits);
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
`ifdef PE_GRID_SATURATE_EN
    begin
      logic signed [2*DATA_W-1:0] shifted;
      shifted = prod >>> fracBits;
      if (shifted > (2*DATA_W)'(DATA_MAX))
        return DATA_MAX;
      else if (shifted < (2*DATA_W)'(DATA_MIN))
        return DATA_MIN;
      else
        return DATA_W'(shifted);
    end
`else
    return DATA_W'(prod >>> fracBits);
`endif
  endfunction

  // One extra bit of headroom lets overflow be detected by comparing the
  // two top bits of the widened sum.
  function automatic data_t q_add(input data_t a, input data_t b);
`ifdef PE_GRID_SATURATE_EN
    logic signed [DATA_W:0] sum;
    sum = (DATA_W+1)'(a) + (DATA_W+1)'(b);
    if (sum[DATA_W] != sum[DATA_W-1])
      return sum[DATA_W] ? DATA_MIN : DATA_MAX;
    else
      return DATA_W'(sum);
`else
    return a + b;
`endif
  endfunction

endpackage

// File: rtl/pe_grid_12x14_pe_cell.sv
// Single multiply-accumulate processing element of the PE grid.
//
// Holds one weight, one activation and an activation-valid flag. The
// partial-sum path is purely combinational: psum_o = psum_i + w*a when
// the activation is valid, else psum_o = psum_i.
//
// Ports:
//   clk       clock, all state changes on rising edge
//   rst       synchronous active-high reset, clears all state
//   w_load_i  load w_i into the weight register this edge
//   w_i       weight value
//   a_vld_i   activation valid strobe, sampled every edge
//   a_i       activation value, captured only when a_vld_i is high
//   psum_i    incoming partial sum (from the row below)
//   psum_o    outgoing partial sum (to the row above)
//
// Build option: PE_GRID_SATURATE_EN selects saturating MAC arithmetic.

module pe_cell
  import eyeriss_pkg::*;
#(
  parameter int DATA_W    = eyeriss_pkg::DATA_W,
  parameter int FRAC_BITS = eyeriss_pkg::FRAC_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_load_i,
  input  logic signed [DATA_W-1:0] w_i,
  input  logic                     a_vld_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] psum_i,
  output logic signed [DATA_W-1:0] psum_o
);

  logic signed [DATA_W-1:0] w_q, w_d;
  logic signed [DATA_W-1:0] a_q, a_d;
  logic                     a_vld_q, a_vld_d;
  logic signed [DATA_W-1:0] contrib;

  // Next-state: the weight updates only on a row-load, the activation only
  // while its strobe is high; the valid flag simply follows the strobe.
  always_comb begin
    w_d     = w_q;
    a_d     = a_q;
    a_vld_d = a_vld_i;
    if (w_load_i) w_d = w_i;
    if (a_vld_i)  a_d = a_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      a_q     <= '0;
      a_vld_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
    end
  end

  // An invalid activation contributes nothing, so the partial sum passes
  // straight through this PE.
  assign contrib = a_vld_q ? q_mul(w_q, a_q, FRAC_BITS) : '0;
  assign psum_o  = q_add(psum_i, contrib);

endmodule

// File: rtl/pe_grid_12x14.sv
// 12 x 14 grid of Q7.8 MAC processing elements.
//
// Weights are loaded one grid row at a time (row chosen by tag_row),
// activations are broadcast down each column, and partial sums ripple
// from the bottom row (ROWS-1) up to row 0, which drives psum_outs.
//
// Ports:
//   clk              clock, rising edge
//   rst              synchronous active-high reset
//   image_val_vec    per-column activation values
//   valid_x_vec      per-column activation valid strobes (bit c = column c)
//   row_weight_vals  weights for one grid row, entry c -> column c
//   tag_row          destination row of row_weight_vals
//   valid_y          weight-load strobe
//   psum_ins         partial sums entering row ROWS-1
//   psum_outs        partial sums leaving row 0
//
// Build option: PE_GRID_SATURATE_EN selects saturating MAC arithmetic.

module pe_grid_12x14
  import eyeriss_pkg::*;
#(
  parameter int ROWS      = GRID_ROWS,
  parameter int COLS      = GRID_COLS,
  parameter int DATA_W    = eyeriss_pkg::DATA_W,
  parameter int FRAC_BITS = eyeriss_pkg::FRAC_BITS,
  parameter int TAG_W     = eyeriss_pkg::TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] image_val_vec   [COLS],
  input  logic        [COLS-1:0]   valid_x_vec,
  input  logic signed [DATA_W-1:0] row_weight_vals [COLS],
  input  logic        [TAG_W-1:0]  tag_row,
  input  logic                     valid_y,
  input  logic signed [DATA_W-1:0] psum_ins        [COLS],
  output logic signed [DATA_W-1:0] psum_outs       [COLS]
);

  // psumChain[r] is the partial sum leaving row r; index ROWS is the
  // external input feeding the bottom row.
  logic signed [DATA_W-1:0] psumChain [ROWS+1][COLS];
  logic        [ROWS-1:0]   rowLoad;

  // Tags of ROWS and above match no row, so out-of-range loads are dropped.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_sel
    assign rowLoad[r] = valid_y && (tag_row == TAG_W'(r));
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_io
    assign psumChain[ROWS][c] = psum_ins[c];
    assign psum_outs[c]       = psumChain[0][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      pe_cell #(
        .DATA_W   (DATA_W),
        .FRAC_BITS(FRAC_BITS)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .w_load_i(rowLoad[r]),
        .w_i     (row_weight_vals[c]),
        .a_vld_i (valid_x_vec[c]),
        .a_i     (image_val_vec[c]),
        .psum_i  (psumChain[r+1][c]),
        .psum_o  (psumChain[r][c])
      );
    end
  end

endmodule

// File: tb/tb_pe_grid_12x14.sv
// Directed self-checking bench for pe_grid_12x14.
// Inputs change just after the falling edge; outputs are checked on the
// following falling edge, one rising edge later.

module tb_pe_grid_12x14;

  localparam int NC = 14;

  logic              clk;
  logic              rst;
  logic signed [15:0] imageVals  [NC];
  logic [NC-1:0]     validX;
  logic signed [15:0] rowWeights [NC];
  logic [3:0]        tagRow;
  logic              validY;
  logic signed [15:0] psumIns    [NC];
  logic signed [15:0] psumOuts   [NC];

  int total = 0;
  int bad   = 0;

  pe_grid_12x14 dut (
    .clk            (clk),
    .rst            (rst),
    .image_val_vec  (imageVals),
    .valid_x_vec    (validX),
    .row_weight_vals(rowWeights),
    .tag_row        (tagRow),
    .valid_y        (validY),
    .psum_ins       (psumIns),
    .psum_outs      (psumOuts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land on the next falling edge.
  task automatic applyStimulus();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearWeights();
    for (int c = 0; c < NC; c++) rowWeights[c] = 16'sh0000;
  endtask

  initial begin
    logic [19:0] treeSum;
    logic [15:0] satExp;

    // Reset with everything idle.
    rst    = 1'b1;
    validX = '0;
    validY = 1'b0;
    tagRow = 4'd0;
    for (int c = 0; c < NC; c++) begin
      imageVals[c] = 16'sh0000;
      psumIns[c]   = 16'sh0000;
    end
    clearWeights();
    @(negedge clk);
    applyStimulus();
    rst = 1'b0;

    // After reset every column passes psum straight through.
    for (int c = 0; c < NC; c++) psumIns[c] = 16'(c * 3 + 1);
    #1;
    for (int c = 0; c < NC; c++)
      checkOutput($sformatf("reset_pass c%0d", c), psumOuts[c], 16'(c * 3 + 1));
    for (int c = 0; c < NC; c++) psumIns[c] = 16'sh0000;

    // Identity MAC: rows 0-5, cols 0-5 get 1.0; image 1.0 on cols 0-5.
    $display("[TB] identity load");
    validY = 1'b1;
    for (int r = 0; r < 6; r++) begin
      tagRow = 4'(r);
      for (int c = 0; c < NC; c++) rowWeights[c] = (c < 6) ? 16'sh0100 : 16'sh0000;
      applyStimulus();
    end
    validY = 1'b0;
    for (int c = 0; c < NC; c++) begin
      validX[c]    = (c < 6);
      imageVals[c] = (c < 6) ? 16'sh0100 : 16'sh0000;
    end
    applyStimulus();
    treeSum = '0;
    for (int c = 0; c < NC; c++) begin
      checkOutput($sformatf("identity c%0d", c), psumOuts[c], (c < 6) ? 16'h0600 : 16'h0000);
      treeSum += 20'(psumOuts[c]);
    end
    checkOutput("identity_tree_sum", treeSum[15:0], 16'h2400);

    // Out-of-range tags must not disturb any weights.
    validY = 1'b1;
    tagRow = 4'd13;
    for (int c = 0; c < NC; c++) rowWeights[c] = 16'sh0500;
    applyStimulus();
    tagRow = 4'd12;
    applyStimulus();
    validY = 1'b0;
    for (int c = 0; c < 6; c++)
      checkOutput($sformatf("bad_tag c%0d", c), psumOuts[c], 16'h0600);

    // Drop column 2 valid for one cycle; image changes meanwhile but is not captured.
    validX[2]    = 1'b0;
    imageVals[2] = 16'sh0300;
    psumIns[2]   = 16'sh0123;
    applyStimulus();
    checkOutput("gate_c2_pass", psumOuts[2], 16'h0123);
    checkOutput("gate_c3_unaffected", psumOuts[3], 16'h0600);
    validX[2]    = 1'b1;
    imageVals[2] = 16'sh0100;
    psumIns[2]   = 16'sh0000;
    applyStimulus();
    checkOutput("gate_c2_restore", psumOuts[2], 16'h0600);

    // Reset mid-run clears weights; activations keep streaming but contribute 0.
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    for (int c = 0; c < NC; c++) psumIns[c] = 16'(c);
    applyStimulus();
    for (int c = 0; c < NC; c++)
      checkOutput($sformatf("midreset c%0d", c), psumOuts[c], 16'(c));
    applyStimulus();
    checkOutput("midreset_hold c5", psumOuts[5], 16'h0005);

    // Sign: -1.0 * 1.5 + 0x0040, weight and activation land on the same edge.
    for (int c = 0; c < NC; c++) psumIns[c] = 16'sh0000;
    psumIns[0] = 16'sh0040;
    validX     = '0;
    validX[0]  = 1'b1;
    imageVals[0] = 16'sh0180;
    clearWeights();
    rowWeights[0] = 16'shFF00;
    tagRow = 4'd0;
    validY = 1'b1;
    applyStimulus();
    validY = 1'b0;
    checkOutput("sign c0", psumOuts[0], 16'hFEC0);

    // Overflow, bottom-row load and floor rounding in one pass.
    psumIns[0] = 16'sh0000;
    validX     = '0;
    clearWeights();
    rowWeights[2] = 16'shFFFF;
    tagRow = 4'd5;
    validY = 1'b1;
    applyStimulus();
    clearWeights();
    rowWeights[1] = 16'sh0100;
    tagRow = 4'd11;
    applyStimulus();
    clearWeights();
    rowWeights[0] = 16'sh7F00;
    tagRow = 4'd0;
    validX[0] = 1'b1; imageVals[0] = 16'sh0200;
    validX[1] = 1'b1; imageVals[1] = 16'sh0300;
    validX[2] = 1'b1; imageVals[2] = 16'sh0001;
    applyStimulus();
    validY = 1'b0;
`ifdef PE_GRID_SATURATE_EN
    satExp = 16'h7FFF;
`else
    satExp = 16'hFE00;
`endif
    checkOutput("overflow c0", psumOuts[0], satExp);
    checkOutput("bottom_row c1", psumOuts[1], 16'h0300);
    checkOutput("floor_round c2", psumOuts[2], 16'hFFFF);

    // psum path is combinational.
    psumIns[1] = 16'sh0010;
    #1;
    checkOutput("comb_psum c1", psumOuts[1], 16'h0310);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
